// File: rtl/mem_ctrl_pkg.sv
// Shared constants, length codes and state encoding for the byte-wide RAM controller.
package mem_ctrl_pkg;

   localparam int MEM_ADDR_BUS = 32;
   localparam int MEM_DATA_BUS = 32;
   localparam int IO_BIT_IDX   = 17;

   localparam logic [2:0] LEN_B = 3'b001;
   localparam logic [2:0] LEN_H = 3'b010;
   localparam logic [2:0] LEN_W = 3'b100;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      DONE  = 2'd2,
      WRITE = 2'd3
   } state_t;

   // Malformed one-hot codes fall back to a full word.
   function automatic logic [2:0] len_to_n(input logic [2:0] len);
      logic [2:0] n;
      case (len)
         LEN_B:   n = 3'd1;
         LEN_H:   n = 3'd2;
         default: n = 3'd4;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// Client and RAM-side signal bundle; master is the controller's view, slave the environment's.
interface mem_ctrl_if
   import mem_ctrl_pkg::*;
#(
   parameter int ADDR_W = MEM_ADDR_BUS,
   parameter int DATA_W = MEM_DATA_BUS
);
   logic              ram_read;
   logic [2:0]        ram_length;
   logic              ram_signed;
   logic [ADDR_W-1:0] ram_addr;
   logic              ram_busy;
   logic              ram_ready;
   logic [DATA_W-1:0] ram_data;
   logic              buffer_write;
   logic [2:0]        buffer_length;
   logic [ADDR_W-1:0] buffer_addr;
   logic [DATA_W-1:0] buffer_data;
   logic              buffer_busy;
   logic              inst_read;
   logic [ADDR_W-1:0] inst_addr;
   logic              inst_busy;
   logic              inst_ready;
   logic [DATA_W-1:0] inst_data;
   logic              io_buffer_full;
   logic [7:0]        mem_din;
   logic [7:0]        mem_dout;
   logic [ADDR_W-1:0] mem_a;
   logic              mem_wr;

   modport master (
      input  ram_read, ram_length, ram_signed, ram_addr,
      output ram_busy, ram_ready, ram_data,
      input  buffer_write, buffer_length, buffer_addr, buffer_data,
      output buffer_busy,
      input  inst_read, inst_addr,
      output inst_busy, inst_ready, inst_data,
      input  io_buffer_full, mem_din,
      output mem_dout, mem_a, mem_wr
   );

   modport slave (
      output ram_read, ram_length, ram_signed, ram_addr,
      input  ram_busy, ram_ready, ram_data,
      output buffer_write, buffer_length, buffer_addr, buffer_data,
      input  buffer_busy,
      output inst_read, inst_addr,
      input  inst_busy, inst_ready, inst_data,
      output io_buffer_full, mem_din,
      input  mem_dout, mem_a, mem_wr
   );
endinterface

// File: rtl/mem_ctrl_seq.sv
// Byte sequencer: walks base..base+n-1, one byte per unstalled cycle, starting in the grant cycle.
module mem_ctrl_seq
   import mem_ctrl_pkg::*;
#(
   parameter int ADDR_W = MEM_ADDR_BUS
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic [2:0]        start_n,
   input  logic [ADDR_W-1:0] start_addr,
   input  logic              stall,
   output logic [ADDR_W-1:0] addr,
   output logic [1:0]        idx,
   output logic              xfer,
   output logic              last
);
   logic              run;
   logic [1:0]        k;
   logic [2:0]        n;
   logic [ADDR_W-1:0] base;
   logic [ADDR_W-1:0] addr_q;
   logic              drive;
   logic [1:0]        cur_k;
   logic [2:0]        cur_n;
   logic [ADDR_W-1:0] cur_base;

   always_comb begin
      drive    = !reset && (start || run);
      cur_k    = start ? 2'd0 : k;
      cur_n    = start ? start_n : n;
      cur_base = start ? start_addr : base;
      idx      = cur_k;
      xfer     = drive && !stall;
      last     = xfer && ({1'b0, cur_k} == (cur_n - 3'd1));
      // Between transfers the address bus parks on the last byte driven.
      addr     = drive ? (cur_base + {{(ADDR_W-2){1'b0}}, cur_k}) : addr_q;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         run    <= 1'b0;
         k      <= 2'd0;
         addr_q <= '0;
      end else begin
         if (start) begin
            base <= start_addr;
            n    <= start_n;
         end
         if (drive)
            addr_q <= addr;
         if (xfer) begin
            run <= !last;
            k   <= last ? 2'd0 : cur_k + 2'd1;
         end else if (start) begin
            run <= 1'b1;
            k   <= 2'd0;
         end
      end
   end
endmodule

// File: rtl/mem_ctrl.sv
// Single-port RAM controller: fixed-priority arbitration of write buffer, D-side reads and fetch,
// little-endian byte reassembly with sign/zero extension.
module mem_ctrl
   import mem_ctrl_pkg::*;
#(
   parameter int ADDR_W = MEM_ADDR_BUS,
   parameter int DATA_W = MEM_DATA_BUS,
   parameter int IO_BIT = IO_BIT_IDX
) (
   input logic        clock,
   input logic        reset,
   mem_ctrl_if.master bus
);
   state_t            state;
   logic              pend;
   logic [2:0]        pend_len;
   logic [ADDR_W-1:0] pend_addr;
   logic [DATA_W-1:0] pend_data;
   logic              rd_inst;
   logic              rd_signed;
   logic [2:0]        rd_n;
   logic [1:0]        cap_k;
   logic [DATA_W-1:0] asm_q;
   logic [DATA_W-1:0] asm_next;
   logic              ram_ready_q, inst_ready_q;
   logic [DATA_W-1:0] ram_data_q, inst_data_q;
   logic [7:0]        dout_q;

   logic              idle, gnt_wr, gnt_rd, gnt_if, start;
   logic [2:0]        start_len;
   logic [ADDR_W-1:0] start_addr;
   logic              wr_phase, stall, wr_xfer, buf_busy;
   logic [ADDR_W-1:0] seq_addr;
   logic [1:0]        seq_idx;
   logic              seq_xfer, seq_last;
   logic [7:0]        dout_c;

   function automatic logic [DATA_W-1:0] extend(input logic [DATA_W-1:0] raw,
                                                input logic [2:0] n, input logic sgn);
      logic [DATA_W-1:0] r;
      r = raw;
      case (n)
         3'd1:    r = {{(DATA_W-8){sgn & raw[7]}}, raw[7:0]};
         3'd2:    r = {{(DATA_W-16){sgn & raw[15]}}, raw[15:0]};
         default: r = raw;
      endcase
      return r;
   endfunction

   always_comb begin
      idle       = (state == IDLE) && !reset;
      gnt_wr     = idle && pend;
      gnt_rd     = idle && !pend && bus.ram_read;
      gnt_if     = idle && !pend && !bus.ram_read && bus.inst_read;
      start      = gnt_wr || gnt_rd || gnt_if;
      start_len  = gnt_wr ? pend_len  : (gnt_rd ? bus.ram_length : LEN_W);
      start_addr = gnt_wr ? pend_addr : (gnt_rd ? bus.ram_addr   : bus.inst_addr);
      wr_phase   = gnt_wr || (state == WRITE);
      stall      = wr_phase && pend_addr[IO_BIT] && bus.io_buffer_full;
      wr_xfer    = wr_phase && seq_xfer;
      dout_c     = wr_xfer ? pend_data[8*seq_idx +: 8] : dout_q;
      buf_busy   = pend || (state == WRITE);
      asm_next   = asm_q;
      asm_next[8*cap_k +: 8] = bus.mem_din;
   end

   mem_ctrl_seq #(.ADDR_W(ADDR_W)) u_seq (
      .clock      (clock),
      .reset      (reset),
      .start      (start),
      .start_n    (len_to_n(start_len)),
      .start_addr (start_addr),
      .stall      (stall),
      .addr       (seq_addr),
      .idx        (seq_idx),
      .xfer       (seq_xfer),
      .last       (seq_last)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state        <= IDLE;
         pend         <= 1'b0;
         cap_k        <= 2'd0;
         ram_ready_q  <= 1'b0;
         inst_ready_q <= 1'b0;
         ram_data_q   <= '0;
         inst_data_q  <= '0;
         dout_q       <= 8'h00;
      end else begin
         ram_ready_q  <= 1'b0;
         inst_ready_q <= 1'b0;
         if (wr_xfer)
            dout_q <= dout_c;
         // A pulse while busy cannot happen legally and is dropped.
         if (bus.buffer_write && !buf_busy) begin
            pend      <= 1'b1;
            pend_len  <= bus.buffer_length;
            pend_addr <= bus.buffer_addr;
            pend_data <= bus.buffer_data;
         end
         case (state)
            IDLE: begin
               if (gnt_wr) begin
                  pend <= 1'b0;
                  if (!seq_last)
                     state <= WRITE;
               end else if (gnt_rd || gnt_if) begin
                  state     <= READ;
                  rd_inst   <= gnt_if;
                  rd_signed <= bus.ram_signed;
                  rd_n      <= len_to_n(start_len);
                  cap_k     <= 2'd0;
                  asm_q     <= '0;
               end
            end
            READ: begin
               // RAM returns each byte one cycle after its address.
               asm_q <= asm_next;
               if ({1'b0, cap_k} == (rd_n - 3'd1)) begin
                  state <= DONE;
                  if (rd_inst) begin
                     inst_ready_q <= 1'b1;
                     inst_data_q  <= asm_next;
                  end else begin
                     ram_ready_q <= 1'b1;
                     ram_data_q  <= extend(asm_next, rd_n, rd_signed);
                  end
               end else begin
                  cap_k <= cap_k + 2'd1;
               end
            end
            DONE:  state <= IDLE;
            WRITE: if (seq_last) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.ram_busy    = (state != IDLE);
   assign bus.inst_busy   = (state != IDLE);
   assign bus.buffer_busy = buf_busy;
   assign bus.ram_ready   = ram_ready_q;
   assign bus.ram_data    = ram_data_q;
   assign bus.inst_ready  = inst_ready_q;
   assign bus.inst_data   = inst_data_q;
   assign bus.mem_a       = seq_addr;
   assign bus.mem_wr      = wr_xfer;
   assign bus.mem_dout    = dout_c;
endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl with a byte RAM model whose read data lags the address by one cycle.
module tb_mem_ctrl;
   import mem_ctrl_pkg::*;

   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   mem_ctrl_if #(.ADDR_W(32), .DATA_W(32)) bus ();
   mem_ctrl #(.ADDR_W(32), .DATA_W(32), .IO_BIT(17)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   logic [7:0]  ram [0:4095];
   logic        ld_en;
   logic [11:0] ld_a;
   logic [7:0]  ld_d;

   always @(posedge clock) begin
      if (ld_en)
         ram[ld_a] <= ld_d;
      else if (bus.mem_wr)
         ram[bus.mem_a[11:0]] <= bus.mem_dout;
      bus.mem_din <= ram[bus.mem_a[11:0]];
   end

   int nvec = 0;
   int nerr = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic dread(input string tag, input logic [31:0] a, input logic [2:0] len,
                        input logic sgn, input logic [31:0] exp, input int n);
      int          lat;
      int          pulses;
      logic [31:0] got;
      lat = -1;
      pulses = 0;
      got = 32'h0;
      bus.ram_read   = 1'b1;
      bus.ram_length = len;
      bus.ram_addr   = a;
      bus.ram_signed = sgn;
      for (int i = 0; i < n + 6; i++) begin
         @(negedge clock);
         if (i < n) check({tag, ".mem_a"}, bus.mem_a, a + i);
         if (bus.ram_ready) begin
            pulses++;
            if (lat < 0) begin
               lat = i;
               got = bus.ram_data;
            end
         end
         tick();
         if (lat >= 0) bus.ram_read = 1'b0;
      end
      check({tag, ".latency"}, 32'(lat), 32'(n + 1));
      check({tag, ".data"}, got, exp);
      check({tag, ".pulses"}, 32'(pulses), 32'd1);
   endtask

   logic [11:0] pl_a [12] = '{12'h100, 12'h101, 12'h102, 12'h103, 12'h120, 12'h130,
                              12'h131, 12'h140, 12'h141, 12'h142, 12'h143, 12'h000};
   logic [7:0]  pl_d [12] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h80, 8'h01,
                              8'h80, 8'hD4, 8'hC3, 8'hB2, 8'hA1, 8'h00};

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int          nwr, wr_i, rcnt, r_i, icnt, i_i, stray;
      logic [31:0] wr_a, rdat, idat;
      logic [7:0]  wr_d;
      bit   [3:0]  hw_busy;
      bit   [5:0]  io_busy, io_wr;

      bus.ram_read = 1'b0; bus.ram_length = LEN_W; bus.ram_signed = 1'b0; bus.ram_addr = '0;
      bus.buffer_write = 1'b0; bus.buffer_length = LEN_B; bus.buffer_addr = '0; bus.buffer_data = '0;
      bus.inst_read = 1'b0; bus.inst_addr = '0; bus.io_buffer_full = 1'b0;
      ld_en = 1'b0; ld_a = '0; ld_d = '0;
      reset = 1'b1;
      tick();
      for (int i = 0; i < 12; i++) begin
         ld_en = 1'b1; ld_a = pl_a[i]; ld_d = pl_d[i];
         tick();
      end
      ld_en = 1'b0;

      // Reset state
      @(negedge clock);
      check("rst.mem_wr", 32'(bus.mem_wr), 32'd0);
      check("rst.mem_a", bus.mem_a, 32'h0);
      check("rst.mem_dout", 32'(bus.mem_dout), 32'h0);
      check("rst.ready", {30'd0, bus.ram_ready, bus.inst_ready}, 32'd0);
      check("rst.ram_data", bus.ram_data, 32'h0);
      check("rst.inst_data", bus.inst_data, 32'h0);
      check("rst.busy", {29'd0, bus.ram_busy, bus.inst_busy, bus.buffer_busy}, 32'd0);
      tick();
      reset = 1'b0;
      tick();

      dread("rd_word", 32'h100, LEN_W, 1'b0, 32'h44332211, 4);
      dread("rd_sbyte", 32'h120, LEN_B, 1'b1, 32'hFFFFFF80, 1);
      dread("rd_uhalf", 32'h130, LEN_H, 1'b0, 32'h00008001, 2);
      dread("rd_shalf", 32'h130, LEN_H, 1'b1, 32'hFFFF8001, 2);
      dread("rd_badlen", 32'h100, 3'b011, 1'b1, 32'h44332211, 4);

      // Half write of 0xBEEF at 0x200
      hw_busy = 4'b0110;
      bus.buffer_write = 1'b1; bus.buffer_length = LEN_H;
      bus.buffer_addr = 32'h200; bus.buffer_data = 32'h0000BEEF;
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         check("wh.busy", 32'(bus.buffer_busy), 32'(hw_busy[i]));
         check("wh.mem_wr", 32'(bus.mem_wr), 32'(hw_busy[i]));
         if (i == 1 || i == 2) begin
            check("wh.mem_a", bus.mem_a, 32'h200 + i - 1);
            check("wh.mem_dout", 32'(bus.mem_dout), (i == 1) ? 32'hEF : 32'hBE);
         end
         tick();
         bus.buffer_write = 1'b0;
      end
      dread("rd_back_half", 32'h200, LEN_H, 1'b0, 32'h0000BEEF, 2);

      // Pending write beats D read, which beats fetch
      nwr = 0; wr_i = -1; wr_a = '0; wr_d = '0;
      rcnt = 0; r_i = -1; rdat = '0; icnt = 0; i_i = -1; idat = '0;
      bus.buffer_write = 1'b1; bus.buffer_length = LEN_B;
      bus.buffer_addr = 32'h210; bus.buffer_data = 32'h0000005A;
      for (int i = 0; i < 20; i++) begin
         if (i == 1) begin
            bus.ram_read = 1'b1; bus.ram_length = LEN_W; bus.ram_addr = 32'h100; bus.ram_signed = 1'b0;
            bus.inst_read = 1'b1; bus.inst_addr = 32'h140;
         end
         @(negedge clock);
         if (bus.mem_wr) begin nwr++; wr_i = i; wr_a = bus.mem_a; wr_d = bus.mem_dout; end
         if (bus.ram_ready) begin rcnt++; r_i = i; rdat = bus.ram_data; end
         if (bus.inst_ready) begin icnt++; i_i = i; idat = bus.inst_data; end
         if (i == 7) check("prio.done_a_held", bus.mem_a, 32'h103);
         if (i == 13) check("prio.ifdone_a_held", bus.mem_a, 32'h143);
         tick();
         bus.buffer_write = 1'b0;
         if (rcnt > 0) bus.ram_read = 1'b0;
         if (icnt > 0) bus.inst_read = 1'b0;
      end
      check("prio.nwr", 32'(nwr), 32'd1);
      check("prio.wr_cycle", 32'(wr_i), 32'd1);
      check("prio.wr_addr", wr_a, 32'h210);
      check("prio.wr_byte", 32'(wr_d), 32'h5A);
      check("prio.rd_pulses", 32'(rcnt), 32'd1);
      check("prio.rd_cycle", 32'(r_i), 32'd7);
      check("prio.rd_data", rdat, 32'h44332211);
      check("prio.if_pulses", 32'(icnt), 32'd1);
      check("prio.if_cycle", 32'(i_i), 32'd13);
      check("prio.if_data", idat, 32'hA1B2C3D4);
      dread("rd_back_byte", 32'h210, LEN_B, 1'b0, 32'h0000005A, 1);

      // IO-region byte write held off by io_buffer_full for three cycles
      io_busy = 6'b011110;
      io_wr   = 6'b010000;
      bus.buffer_write = 1'b1; bus.buffer_length = LEN_B;
      bus.buffer_addr = 32'h30000; bus.buffer_data = 32'h00000077;
      for (int i = 0; i < 6; i++) begin
         bus.io_buffer_full = (i <= 3);
         @(negedge clock);
         check("io.busy", 32'(bus.buffer_busy), 32'(io_busy[i]));
         check("io.mem_wr", 32'(bus.mem_wr), 32'(io_wr[i]));
         if (i == 4) begin
            check("io.mem_a", bus.mem_a, 32'h30000);
            check("io.mem_dout", 32'(bus.mem_dout), 32'h77);
         end
         tick();
         bus.buffer_write = 1'b0;
      end
      bus.io_buffer_full = 1'b0;

      // Reset in the middle of a word read
      stray = 0;
      bus.ram_read = 1'b1; bus.ram_length = LEN_W; bus.ram_addr = 32'h100; bus.ram_signed = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (i == 2) begin reset = 1'b1; bus.ram_read = 1'b0; end
         if (i == 3) reset = 1'b0;
         @(negedge clock);
         if (bus.ram_ready) stray++;
         if (i == 3) begin
            check("mrst.mem_wr", 32'(bus.mem_wr), 32'd0);
            check("mrst.mem_a", bus.mem_a, 32'h0);
            check("mrst.mem_dout", 32'(bus.mem_dout), 32'h0);
            check("mrst.ram_data", bus.ram_data, 32'h0);
            check("mrst.inst_data", bus.inst_data, 32'h0);
            check("mrst.busy", {29'd0, bus.ram_busy, bus.inst_busy, bus.buffer_busy}, 32'd0);
         end
         tick();
      end
      check("mrst.no_ready", 32'(stray), 32'd0);
      dread("rd_after_rst", 32'h100, LEN_W, 1'b0, 32'h44332211, 4);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
